// File: rtl/icmp_echo_responder.sv
// ICMP echo responder for a 256-bit AXI4-Stream datapath: IPv4 echo requests are reflected as
// echo replies (MAC/IP swap, type 8->0, incremental checksum); everything else passes bit-exact.

module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_C = DEPTH[MAX_DEPTH_BITS:0];
  localparam logic [MAX_DEPTH_BITS:0] NEAR_C  = DEPTH_C - {{MAX_DEPTH_BITS{1'b0}}, 1'b1};

  logic [WIDTH-1:0]          mem_r [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_r;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_r;
  logic [MAX_DEPTH_BITS:0]   count_r;
  logic                      do_wr_s;
  logic                      do_rd_s;

  assign empty       = (count_r == '0);
  assign nearly_full = (count_r >= NEAR_C);
  assign do_wr_s     = wr_en && (count_r != DEPTH_C);
  assign do_rd_s     = rd_en && !empty;
  assign dout        = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; the head entry is visible on dout without a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

module icmp_echo_responder #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                                 axis_aclk,
  input  logic                                 axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  input  logic                                 s_axis_tlast,
  output logic                                 s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [31:0]                          reply_count,
  output logic [31:0]                          bypass_count
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int FW = DW + KW + UW + 1;

  typedef enum logic [2:0] {HEAD0, HEAD1, OUT0, OUT1, BODY} state_t;

  // Ones-complement incremental update for the type byte dropping from 0x08 to 0x00.
  function automatic logic [15:0] icmp_csum_adjust(input logic [15:0] c);
    logic [16:0] s;
    s = {1'b0, c} + 17'h00800;
    return s[15:0] + {15'h0000, s[16]};
  endfunction

  function automatic logic icmp_echo_match(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                                           input logic [7:0] src_port);
    return (b0[103:96] == 8'h08) && (b0[111:104] == 8'h00) && (b0[119:112] == 8'h45) &&
           ((b0[167:160] & 8'h3F) == 8'h00) && (b0[175:168] == 8'h00) &&
           (b0[191:184] == 8'h01) && (b1[23:16] == 8'h08) && (b1[31:24] == 8'h00) &&
           (src_port != 8'h00);
  endfunction

  logic [FW-1:0] fifo_din_s;
  logic [FW-1:0] fifo_dout_s;
  logic          fifo_empty_s;
  logic          fifo_nearly_full_s;
  logic          fifo_rd_s;
  logic [DW-1:0] fifo_data_s;
  logic [KW-1:0] fifo_keep_s;
  logic [UW-1:0] fifo_user_s;
  logic          fifo_last_s;

  state_t        state_r;
  logic [DW-1:0] out0_data_r;
  logic [KW-1:0] out0_keep_r;
  logic [UW-1:0] out0_user_r;
  logic          out0_last_r;
  logic [DW-1:0] out1_data_r;
  logic [KW-1:0] out1_keep_r;
  logic [UW-1:0] out1_user_r;
  logic          out1_last_r;
  logic          matched_r;
  logic [31:0]   reply_count_r;
  logic [31:0]   bypass_count_r;

  logic          is_match_s;
  logic [DW-1:0] rew0_data_s;
  logic [UW-1:0] rew0_user_s;
  logic [DW-1:0] rew1_data_s;
  logic [UW-1:0] rew1_user_s;
  logic [15:0]   csum_new_s;

  assign fifo_din_s = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  assign {fifo_last_s, fifo_user_s, fifo_keep_s, fifo_data_s} = fifo_dout_s;
  assign s_axis_tready = !fifo_nearly_full_s;
  assign reply_count   = reply_count_r;
  assign bypass_count  = bypass_count_r;

  fallthrough_small_fifo #(
    .WIDTH          (FW),
    .MAX_DEPTH_BITS (2)
  ) u_in_fifo (
    .clk         (axis_aclk),
    .rst_n       (axis_resetn),
    .din         (fifo_din_s),
    .wr_en       (s_axis_tvalid & s_axis_tready),
    .rd_en       (fifo_rd_s),
    .dout        (fifo_dout_s),
    .nearly_full (fifo_nearly_full_s),
    .empty       (fifo_empty_s)
  );

  // Reply image of both header beats, built while beat 1 sits at the FIFO head and beat 0
  // is already staged; the IP swap needs bytes from both beats.
  always_comb begin
    is_match_s  = icmp_echo_match(out0_data_r, fifo_data_s, out0_user_r[SRC_PORT_POS +: 8]);
    csum_new_s  = icmp_csum_adjust({fifo_data_s[39:32], fifo_data_s[47:40]});
    rew0_data_s = out0_data_r;
    rew0_data_s[47:0]    = out0_data_r[95:48];
    rew0_data_s[95:48]   = out0_data_r[47:0];
    rew0_data_s[223:208] = out0_data_r[255:240];
    rew0_data_s[239:224] = fifo_data_s[15:0];
    rew0_data_s[255:240] = out0_data_r[223:208];
    rew1_data_s = fifo_data_s;
    rew1_data_s[15:0]  = out0_data_r[239:224];
    rew1_data_s[23:16] = 8'h00;
    rew1_data_s[39:32] = csum_new_s[15:8];
    rew1_data_s[47:40] = csum_new_s[7:0];
    rew0_user_s = out0_user_r;
    rew0_user_s[DST_PORT_POS +: 8] = out0_user_r[SRC_PORT_POS +: 8];
    rew1_user_s = fifo_user_s;
    rew1_user_s[DST_PORT_POS +: 8] = fifo_user_s[SRC_PORT_POS +: 8];
  end

  // FIFO pops happen only while staging headers or streaming the body.
  always_comb begin
    fifo_rd_s = 1'b0;
    case (state_r)
      HEAD0, HEAD1: fifo_rd_s = !fifo_empty_s;
      BODY:         fifo_rd_s = !fifo_empty_s && m_axis_tready;
      default:      fifo_rd_s = 1'b0;
    endcase
  end

  // Header staging / emission sequencer and packet counters.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_r        <= HEAD0;
      out0_data_r    <= '0;
      out0_keep_r    <= '0;
      out0_user_r    <= '0;
      out0_last_r    <= 1'b0;
      out1_data_r    <= '0;
      out1_keep_r    <= '0;
      out1_user_r    <= '0;
      out1_last_r    <= 1'b0;
      matched_r      <= 1'b0;
      reply_count_r  <= 32'h0000_0000;
      bypass_count_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        HEAD0: begin
          if (!fifo_empty_s) begin
            out0_data_r <= fifo_data_s;
            out0_keep_r <= fifo_keep_s;
            out0_user_r <= fifo_user_s;
            out0_last_r <= fifo_last_s;
            matched_r   <= 1'b0;
            state_r     <= fifo_last_s ? OUT0 : HEAD1;
          end
        end
        HEAD1: begin
          if (!fifo_empty_s) begin
            matched_r   <= is_match_s;
            out1_keep_r <= fifo_keep_s;
            out1_last_r <= fifo_last_s;
            if (is_match_s) begin
              out0_data_r <= rew0_data_s;
              out0_user_r <= rew0_user_s;
              out1_data_r <= rew1_data_s;
              out1_user_r <= rew1_user_s;
            end else begin
              out1_data_r <= fifo_data_s;
              out1_user_r <= fifo_user_s;
            end
            state_r <= OUT0;
          end
        end
        OUT0: begin
          if (m_axis_tready) begin
            if (out0_last_r) begin
              bypass_count_r <= bypass_count_r + 32'd1;
              state_r        <= HEAD0;
            end else begin
              state_r <= OUT1;
            end
          end
        end
        OUT1: begin
          if (m_axis_tready) begin
            if (matched_r) begin
              reply_count_r <= reply_count_r + 32'd1;
            end else begin
              bypass_count_r <= bypass_count_r + 32'd1;
            end
            state_r <= out1_last_r ? HEAD0 : BODY;
          end
        end
        BODY: begin
          if (!fifo_empty_s && m_axis_tready && fifo_last_s) begin
            state_r <= HEAD0;
          end
        end
        default: state_r <= HEAD0;
      endcase
    end
  end

  // Egress mux: staged header beats, then the FIFO head streamed straight through.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    case (state_r)
      OUT0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = out0_data_r;
        m_axis_tkeep  = out0_keep_r;
        m_axis_tuser  = out0_user_r;
        m_axis_tlast  = out0_last_r;
      end
      OUT1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = out1_data_r;
        m_axis_tkeep  = out1_keep_r;
        m_axis_tuser  = out1_user_r;
        m_axis_tlast  = out1_last_r;
      end
      BODY: begin
        m_axis_tvalid = !fifo_empty_s;
        m_axis_tdata  = fifo_data_s;
        m_axis_tkeep  = fifo_keep_s;
        m_axis_tuser  = fifo_user_s;
        m_axis_tlast  = fifo_last_s;
      end
      default: begin
        m_axis_tvalid = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_icmp_echo_responder.sv
// Directed bench for icmp_echo_responder: echo rewrites, checksum wrap, bypass, back-pressure
// and mid-packet reset, with expected packets built independently from field values.

module tb_icmp_echo_responder;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] s_data;
  logic [31:0]  s_keep;
  logic [127:0] s_user;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [255:0] m_data;
  logic [31:0]  m_keep;
  logic [127:0] m_user;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic [31:0]  reply_count;
  logic [31:0]  bypass_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_low = 0;
  int stall_viol = 0;

  logic [255:0] od_q [$];
  logic [127:0] ou_q [$];
  logic [31:0]  ok_q [$];
  logic         ol_q [$];
  int           oc_q [$];
  int           ic_q [$];

  logic         p_stall = 1'b0;
  logic [255:0] p_data = '0;
  logic [127:0] p_user = '0;
  logic [31:0]  p_keep = '0;
  logic         p_last = 1'b0;

  always #5 clk = ~clk;

  icmp_echo_responder dut (
    .axis_aclk     (clk),
    .axis_resetn   (rst_n),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tuser  (s_user),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tuser  (m_user),
    .m_axis_tvalid (m_valid),
    .m_axis_tlast  (m_last),
    .m_axis_tready (m_ready),
    .reply_count   (reply_count),
    .bypass_count  (bypass_count)
  );

  // Monitor: records accepted input beats, emitted output beats and output instability.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (s_valid && s_ready) ic_q.push_back(cyc);
      if (!s_ready) ready_low <= ready_low + 1;
      if (p_stall && !(m_valid === 1'b1 && m_data === p_data && m_user === p_user &&
                       m_keep === p_keep && m_last === p_last))
        stall_viol <= stall_viol + 1;
      if (m_valid && m_ready) begin
        od_q.push_back(m_data);
        ou_q.push_back(m_user);
        ok_q.push_back(m_keep);
        ol_q.push_back(m_last);
        oc_q.push_back(cyc);
      end
      p_stall <= m_valid && !m_ready;
      p_data  <= m_data;
      p_user  <= m_user;
      p_keep  <= m_keep;
      p_last  <= m_last;
    end else begin
      p_stall <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Header bytes 0..63 of an Ethernet/IPv4/ICMP-like frame, packet byte n at bits [8n+7:8n].
  function automatic logic [511:0] mk_hdr(input logic [47:0] dmac, input logic [47:0] smac,
                                          input logic [31:0] sip, input logic [31:0] dip,
                                          input logic [7:0] proto, input logic [7:0] ityp,
                                          input logic [15:0] csum);
    logic [511:0] p;
    for (int n = 0; n < 64; n++) p[8*n +: 8] = 8'(n * 3 + 1);
    for (int i = 0; i < 6; i++) begin
      p[8*i +: 8]     = dmac[8*(5-i) +: 8];
      p[8*(6+i) +: 8] = smac[8*(5-i) +: 8];
    end
    p[8*12 +: 8] = 8'h08; p[8*13 +: 8] = 8'h00; p[8*14 +: 8] = 8'h45; p[8*15 +: 8] = 8'h00;
    p[8*16 +: 8] = 8'h00; p[8*17 +: 8] = 8'h3C; p[8*20 +: 8] = 8'h40; p[8*21 +: 8] = 8'h00;
    p[8*22 +: 8] = 8'h40; p[8*23 +: 8] = proto; p[8*24 +: 8] = 8'hB1; p[8*25 +: 8] = 8'hE6;
    for (int i = 0; i < 4; i++) begin
      p[8*(26+i) +: 8] = sip[8*(3-i) +: 8];
      p[8*(30+i) +: 8] = dip[8*(3-i) +: 8];
    end
    p[8*34 +: 8] = ityp; p[8*35 +: 8] = 8'h00;
    p[8*36 +: 8] = csum[15:8]; p[8*37 +: 8] = csum[7:0];
    return p;
  endfunction

  function automatic logic [255:0] body(input int k);
    return {8{32'(32'hB0D0_0000 + k)}};
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u,
                           input logic l);
    int g = 0;
    @(negedge clk);
    s_data = d; s_keep = k; s_user = u; s_last = l; s_valid = 1'b1;
    while (!s_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("send_timeout", 256'(g >= 200), 256'd0);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    int g = 0;
    while (od_q.size() < n && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 256'(od_q.size() >= n), 256'd1);
  endtask

  localparam logic [47:0]  MAC_A = 48'h02_00_00_00_00_0A;
  localparam logic [47:0]  MAC_B = 48'h02_00_00_00_00_0B;
  localparam logic [31:0]  IP_1  = 32'h0A00_0001;
  localparam logic [31:0]  IP_2  = 32'h0A00_0002;
  localparam logic [127:0] U_REQ = 128'h0000_0000_0000_0000_0000_0000_0001_0040;
  localparam logic [127:0] U_REP = 128'h0000_0000_0000_0000_0000_0000_0101_0040;
  localparam logic [127:0] U_TCP = 128'h1234_5678_0000_0000_0000_0000_0302_0040;

  initial begin
    logic [511:0] pk;
    logic [511:0] ex;
    int ob;
    int ib;
    int rl;
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0; s_user = '0;
    m_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 256'(m_valid), 256'd0);
    chk("rst_tdata", m_data, 256'd0);
    chk("rst_reply", 256'(reply_count), 256'd0);
    chk("rst_bypass", 256'(bypass_count), 256'd0);
    chk("rst_s_tready", 256'(s_ready), 256'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-beat echo request, full rate
    ob = od_q.size(); ib = ic_q.size();
    pk = mk_hdr(MAC_A, MAC_B, IP_1, IP_2, 8'h01, 8'h08, 16'hFA00);
    ex = mk_hdr(MAC_B, MAC_A, IP_2, IP_1, 8'h01, 8'h00, 16'h0201);
    send_beat(pk[255:0], 32'hFFFF_FFFF, U_REQ, 1'b0);
    send_beat(pk[511:256], 32'h0000_0FFF, 128'd0, 1'b1);
    idle();
    wait_out("echo_wait", ob + 2);
    chk("echo_b0_data", od_q[ob], ex[255:0]);
    chk("echo_b0_user", 256'(ou_q[ob]), 256'(U_REP));
    chk("echo_b0_last", 256'(ol_q[ob]), 256'd0);
    chk("echo_b1_data", od_q[ob+1], ex[511:256]);
    chk("echo_b1_keep", 256'(ok_q[ob+1]), 256'h0FFF);
    chk("echo_b1_last", 256'(ol_q[ob+1]), 256'd1);
    chk("echo_lat_out0", 256'(oc_q[ob] - ic_q[ib]), 256'd3);
    chk("echo_lat_out1", 256'(oc_q[ob+1] - oc_q[ob]), 256'd1);
    chk("echo_reply_cnt", 256'(reply_count), 256'd1);
    chk("echo_bypass_cnt", 256'(bypass_count), 256'd0);

    // Checksum boundaries: no carry into 0xFFFF, and end-around carry to 0x0001
    ob = od_q.size();
    pk = mk_hdr(MAC_A, MAC_B, IP_1, IP_2, 8'h01, 8'h08, 16'hF7FF);
    ex = mk_hdr(MAC_B, MAC_A, IP_2, IP_1, 8'h01, 8'h00, 16'hFFFF);
    send_beat(pk[255:0], 32'hFFFF_FFFF, U_REQ, 1'b0);
    send_beat(pk[511:256], 32'h0000_0FFF, 128'd0, 1'b1);
    idle();
    wait_out("csum_ffff_wait", ob + 2);
    chk("csum_ffff_b1", od_q[ob+1], ex[511:256]);
    ob = od_q.size();
    pk = mk_hdr(MAC_A, MAC_B, IP_1, IP_2, 8'h01, 8'h08, 16'hF800);
    ex = mk_hdr(MAC_B, MAC_A, IP_2, IP_1, 8'h01, 8'h00, 16'h0001);
    send_beat(pk[255:0], 32'hFFFF_FFFF, U_REQ, 1'b0);
    send_beat(pk[511:256], 32'h0000_0FFF, 128'd0, 1'b1);
    idle();
    wait_out("csum_0001_wait", ob + 2);
    chk("csum_0001_b1", od_q[ob+1], ex[511:256]);
    chk("csum_reply_cnt", 256'(reply_count), 256'd3);

    // Four-beat TCP packet passes untouched
    ob = od_q.size();
    pk = mk_hdr(MAC_A, MAC_B, IP_1, IP_2, 8'h06, 8'h08, 16'hFA00);
    send_beat(pk[255:0], 32'hFFFF_FFFF, U_TCP, 1'b0);
    send_beat(pk[511:256], 32'hFFFF_FFFF, U_TCP, 1'b0);
    send_beat(body(0), 32'hFFFF_FFFF, U_TCP, 1'b0);
    send_beat(body(1), 32'h0000_00FF, U_TCP, 1'b1);
    idle();
    wait_out("tcp_wait", ob + 4);
    chk("tcp_b0_data", od_q[ob], pk[255:0]);
    chk("tcp_b0_user", 256'(ou_q[ob]), 256'(U_TCP));
    chk("tcp_b1_data", od_q[ob+1], pk[511:256]);
    chk("tcp_b1_user", 256'(ou_q[ob+1]), 256'(U_TCP));
    chk("tcp_b2_data", od_q[ob+2], body(0));
    chk("tcp_b3_data", od_q[ob+3], body(1));
    chk("tcp_b3_keep", 256'(ok_q[ob+3]), 256'h00FF);
    chk("tcp_b3_last", 256'(ol_q[ob+3]), 256'd1);
    chk("tcp_bypass_cnt", 256'(bypass_count), 256'd1);
    chk("tcp_reply_cnt", 256'(reply_count), 256'd3);

    // Single-beat packet that looks like an echo request is still bypassed
    ob = od_q.size();
    pk = mk_hdr(MAC_A, MAC_B, IP_1, IP_2, 8'h01, 8'h08, 16'hFA00);
    send_beat(pk[255:0], 32'h0FFF_FFFF, U_REQ, 1'b1);
    idle();
    wait_out("single_wait", ob + 1);
    chk("single_data", od_q[ob], pk[255:0]);
    chk("single_user", 256'(ou_q[ob]), 256'(U_REQ));
    chk("single_keep", 256'(ok_q[ob]), 256'h0FFF_FFFF);
    chk("single_last", 256'(ol_q[ob]), 256'd1);
    chk("single_bypass_cnt", 256'(bypass_count), 256'd2);

    // Five-beat echo request under alternating back-pressure
    ob = od_q.size(); rl = ready_low;
    pk = mk_hdr(MAC_A, MAC_B, IP_1, IP_2, 8'h01, 8'h08, 16'h1234);
    ex = mk_hdr(MAC_B, MAC_A, IP_2, IP_1, 8'h01, 8'h00, 16'h1A34);
    fork
      begin
        send_beat(pk[255:0], 32'hFFFF_FFFF, U_REQ, 1'b0);
        send_beat(pk[511:256], 32'hFFFF_FFFF, 128'd0, 1'b0);
        send_beat(body(10), 32'hFFFF_FFFF, 128'd0, 1'b0);
        send_beat(body(11), 32'hFFFF_FFFF, 128'd0, 1'b0);
        send_beat(body(12), 32'h0000_FFFF, 128'd0, 1'b1);
        idle();
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          m_ready = ~m_ready;
        end
        m_ready = 1'b1;
      end
    join
    wait_out("bp_wait", ob + 5);
    repeat (5) @(negedge clk);
    chk("bp_beat_count", 256'(od_q.size() - ob), 256'd5);
    chk("bp_b0_data", od_q[ob], ex[255:0]);
    chk("bp_b0_user", 256'(ou_q[ob]), 256'(U_REP));
    chk("bp_b1_data", od_q[ob+1], ex[511:256]);
    chk("bp_b2_data", od_q[ob+2], body(10));
    chk("bp_b3_data", od_q[ob+3], body(11));
    chk("bp_b4_data", od_q[ob+4], body(12));
    chk("bp_b4_last", 256'(ol_q[ob+4]), 256'd1);
    chk("bp_stall_stable", 256'(stall_viol), 256'd0);
    chk("bp_s_tready_fell", 256'(ready_low > rl), 256'd1);
    chk("bp_reply_cnt", 256'(reply_count), 256'd4);

    // Reset asserted while the body of a six-beat echo request is streaming
    ob = od_q.size();
    pk = mk_hdr(MAC_A, MAC_B, IP_1, IP_2, 8'h01, 8'h08, 16'hFA00);
    send_beat(pk[255:0], 32'hFFFF_FFFF, U_REQ, 1'b0);
    send_beat(pk[511:256], 32'hFFFF_FFFF, 128'd0, 1'b0);
    send_beat(body(20), 32'hFFFF_FFFF, 128'd0, 1'b0);
    send_beat(body(21), 32'hFFFF_FFFF, 128'd0, 1'b0);
    idle();
    wait_out("mid_rst_wait", ob + 3);
    chk("mid_rst_reply_before", 256'(reply_count), 256'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 256'(m_valid), 256'd0);
    chk("mid_rst_reply", 256'(reply_count), 256'd0);
    chk("mid_rst_bypass", 256'(bypass_count), 256'd0);
    chk("mid_rst_tuser", 256'(m_user), 256'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_tvalid_hold", 256'(m_valid), 256'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ob = od_q.size();
    ex = mk_hdr(MAC_B, MAC_A, IP_2, IP_1, 8'h01, 8'h00, 16'h0201);
    send_beat(pk[255:0], 32'hFFFF_FFFF, U_REQ, 1'b0);
    send_beat(pk[511:256], 32'h0000_0FFF, 128'd0, 1'b1);
    idle();
    wait_out("post_rst_wait", ob + 2);
    repeat (4) @(negedge clk);
    chk("post_rst_count", 256'(od_q.size() - ob), 256'd2);
    chk("post_rst_b0", od_q[ob], ex[255:0]);
    chk("post_rst_b1", od_q[ob+1], ex[511:256]);
    chk("post_rst_reply", 256'(reply_count), 256'd1);
    chk("post_rst_bypass", 256'(bypass_count), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
